// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one load/store datapath between the MEM stage (port 0) and a DMA/debug loader (port 1).
// Latency: the grant and memory drive are combinational; the response is registered one cycle after the grant.
// Backpressure: req_ready is the per-port grant; a requester holds its fields stable until it sees req_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      per-port request handshake (bit i = port i)
//   req_we, req_load_type, req_store_type, req_addr, req_wdata
//                            per-port request fields, port i in slice i
//   mem_read/mem_write/mem_load_type/mem_store_type/mem_addr/mem_wdata
//                            drive towards the store datapath and data memory
//   mem_rdata                extended load result from the load datapath (combinational)
//   rsp_valid/rsp_rdata/rsp_err  registered response, one-cycle pulse per access
//   grant_idx                port winning the current cycle (meaningful when req_ready != 0)
module dmem_arbiter #(
  parameter int ARB_MODE     = 0,     // 0 = round-robin, 1 = fixed priority to port 0 with starvation guard
  parameter int STARVE_LIMIT = 4,     // wait cycles before port 1 is forced a grant (ARB_MODE=1), 1..15
  parameter int MEM_BYTES    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [5:0]  req_load_type,
  input  logic [3:0]  req_store_type,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_load_type,
  output logic [1:0]  mem_store_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        grant_idx
);

  typedef struct packed {
    logic        we;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [2:0]  LD_LB  = 3'b000;
  localparam logic [2:0]  LD_LH  = 3'b001;
  localparam logic [2:0]  LD_LW  = 3'b010;
  localparam logic [2:0]  LD_LBU = 3'b011;
  localparam logic [2:0]  LD_LHU = 3'b100;
  localparam logic [1:0]  ST_SH  = 2'b01;
  localparam logic [1:0]  ST_SW  = 2'b10;
  // Highest start address whose 4-byte window still fits inside the memory.
  localparam logic [31:0] ADDR_MAX   = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  req_t       w_req0;
  req_t       w_req1;
  req_t       w_greq;
  req_t       w_mreq;
  logic       w_gidx;
  logic       w_grant;
  logic       w_misalign;
  logic       w_bad_type;
  logic       w_err;
  logic       w_drive;
  logic       r_rr_ptr;
  logic [3:0] r_starve_cnt;

  assign w_req0 = {req_we[0], req_load_type[2:0], req_store_type[1:0], req_addr[31:0],  req_wdata[31:0]};
  assign w_req1 = {req_we[1], req_load_type[5:3], req_store_type[3:2], req_addr[63:32], req_wdata[63:32]};

  // Winner selection. Derived only from req_valid and state, so it stays
  // known even while an idle requester leaves its fields undriven.
  always_comb begin
    w_gidx = 1'b0;
    if (req_valid == 2'b10) begin
      w_gidx = 1'b1;
    end else if (req_valid == 2'b11) begin
      if (ARB_MODE == 0) begin
        w_gidx = r_rr_ptr;
      end else begin
        w_gidx = (r_starve_cnt == STARVE_MAX);
      end
    end
  end

  // No grant while reset is asserted: nothing reaches memory and no response is queued.
  assign w_grant   = ~rst & (|req_valid);
  assign req_ready = w_grant ? (w_gidx ? 2'b10 : 2'b01) : 2'b00;
  assign grant_idx = w_gidx;
  assign w_greq    = w_gidx ? w_req1 : w_req0;

  always_comb begin
    w_misalign = 1'b0;
    w_bad_type = 1'b0;
    if (w_greq.we) begin
      case (w_greq.store_type)
        ST_SH:   w_misalign = w_greq.addr[0];
        ST_SW:   w_misalign = |w_greq.addr[1:0];
        default: w_misalign = 1'b0;
      endcase
    end else begin
      case (w_greq.load_type)
        LD_LB, LD_LBU: w_misalign = 1'b0;
        LD_LH, LD_LHU: w_misalign = w_greq.addr[0];
        LD_LW:         w_misalign = |w_greq.addr[1:0];
        default:       w_bad_type = 1'b1;
      endcase
    end
  end

  assign w_err   = w_misalign | w_bad_type | (w_greq.addr > ADDR_MAX);
  assign w_drive = w_grant & ~w_err;

  // When nothing is driven the field lines follow port 0, but only while it is
  // valid; otherwise they are zeroed so undriven request inputs never leak out.
  assign w_mreq = w_drive ? w_greq : (req_valid[0] ? w_req0 : '0);

  assign mem_read       = w_drive & ~w_mreq.we;
  assign mem_write      = w_drive &  w_mreq.we;
  assign mem_load_type  = w_mreq.load_type;
  assign mem_store_type = w_mreq.store_type;
  assign mem_addr       = w_mreq.addr;
  assign mem_wdata      = w_mreq.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 2'b00;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      rsp_valid <= req_ready;
      rsp_err   <= w_grant & w_err;
      rsp_rdata <= mem_read ? mem_rdata : 32'h0;

      if (w_grant) begin
        r_rr_ptr <= ~w_gidx;
      end

      // Counts cycles port 1 waits while valid; never needs to pass the
      // limit because reaching it guarantees the next grant.
      if (!req_valid[1] || (w_grant && w_gidx)) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011, LHU = 3'b100;
  localparam logic [1:0] SB = 2'b00, SW = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_clr;
  logic [1:0]  req_valid, req_we;
  logic [5:0]  req_load_type;
  logic [3:0]  req_store_type;
  logic [63:0] req_addr, req_wdata;

  logic [1:0]  rdy_a, rsp_valid_a, mst_a;
  logic        mem_read_a, mem_write_a, rsp_err_a, gidx_a;
  logic [2:0]  mlt_a;
  logic [31:0] maddr_a, mwdata_a, mrdata_a, rsp_rdata_a;

  logic [1:0]  rdy_b, rsp_valid_b, mst_b;
  logic        mem_read_b, mem_write_b, rsp_err_b, gidx_b;
  logic [2:0]  mlt_b;
  logic [31:0] maddr_b, mwdata_b, mrdata_b, rsp_rdata_b;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4), .MEM_BYTES(1024)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
    .req_load_type(req_load_type), .req_store_type(req_store_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_load_type(mlt_a), .mem_store_type(mst_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
    .mem_rdata(mrdata_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .grant_idx(gidx_a)
  );

  dmem_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4), .MEM_BYTES(1024)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
    .req_load_type(req_load_type), .req_store_type(req_store_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_load_type(mlt_b), .mem_store_type(mst_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_rdata(mrdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .grant_idx(gidx_b)
  );

  // Byte-addressable little-endian memory plus load/store datapath, one per DUT.
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  logic [9:0] ia, ib;
  assign ia = maddr_a[9:0];
  assign ib = maddr_b[9:0];

  function automatic logic [31:0] ld_ext(input logic [2:0] t, input logic [31:0] w);
    case (t)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b011:  return {24'h0, w[7:0]};
      3'b100:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign mrdata_a = ld_ext(mlt_a, {mem_a[ia + 10'd3], mem_a[ia + 10'd2], mem_a[ia + 10'd1], mem_a[ia]});
  assign mrdata_b = ld_ext(mlt_b, {mem_b[ib + 10'd3], mem_b[ib + 10'd2], mem_b[ib + 10'd1], mem_b[ib]});

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= 8'h00;
    end else if (mem_write_a) begin
      mem_a[ia] <= mwdata_a[7:0];
      if (mst_a != 2'b00) mem_a[ia + 10'd1] <= mwdata_a[15:8];
      if (mst_a == 2'b10) begin
        mem_a[ia + 10'd2] <= mwdata_a[23:16];
        mem_a[ia + 10'd3] <= mwdata_a[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= 8'h00;
    end else if (mem_write_b) begin
      mem_b[ib] <= mwdata_b[7:0];
      if (mst_b != 2'b00) mem_b[ib + 10'd1] <= mwdata_b[15:8];
      if (mst_b == 2'b10) begin
        mem_b[ib + 10'd2] <= mwdata_b[23:16];
        mem_b[ib + 10'd3] <= mwdata_b[31:24];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[p]              = 1'b1;
    req_we[p]                 = we;
    req_load_type[3*p +: 3]   = lt;
    req_store_type[2*p +: 2]  = st;
    req_addr[32*p +: 32]      = a;
    req_wdata[32*p +: 32]     = d;
  endtask

  task automatic clr_req(input int p);
    req_valid[p]              = 1'b0;
    req_we[p]                 = 1'bx;
    req_load_type[3*p +: 3]   = 'x;
    req_store_type[2*p +: 2]  = 'x;
    req_addr[32*p +: 32]      = 'x;
    req_wdata[32*p +: 32]     = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    clr_req(0); clr_req(1);
    tick();
    mem_clr = 1'b0;
    set_req(0, 1'b1, LW, SW, 32'h40, 32'h1);
    #1;
    checks++; if (rdy_a !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", rdy_a); end
    checks++; if (mem_write_a !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", mem_write_a); end
    tick();
    rst = 1'b0;
    clr_req(0);
    #1;
    checks++; if (rsp_valid_a !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid_a); end
    checks++; if (rsp_rdata_a !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata_a); end
    checks++; if (rsp_err_a !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err_a); end
    checks++; if ($isunknown({rdy_a, mem_read_a, mem_write_a, mlt_a, mst_a, maddr_a, mwdata_a}) !== 1'b0) begin
      failures++; $display("FAIL idle_no_x got=%b%b%b %h %h exp=known", rdy_a, mem_read_a, mem_write_a, maddr_a, mwdata_a);
    end
  endtask

  task automatic test_store_load();
    set_req(0, 1'b1, LW, SW, 32'h10, 32'hDEADBEEF);
    #1;
    checks++; if (rdy_a !== 2'b01) begin failures++; $display("FAIL sw_ready got=%b exp=01", rdy_a); end
    checks++; if (mem_write_a !== 1'b1 || mem_read_a !== 1'b0) begin failures++; $display("FAIL sw_mem got=w%b r%b exp=w1 r0", mem_write_a, mem_read_a); end
    checks++; if (maddr_a !== 32'h10) begin failures++; $display("FAIL sw_addr got=%h exp=00000010", maddr_a); end
    tick();
    checks++; if (rsp_valid_a !== 2'b01 || rsp_err_a !== 1'b0) begin failures++; $display("FAIL sw_rsp got=v%b e%b exp=v01 e0", rsp_valid_a, rsp_err_a); end
    checks++; if (rsp_rdata_a !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", rsp_rdata_a); end
    set_req(0, 1'b0, LW, SB, 32'h10, 32'h0);
    #1;
    checks++; if (mem_read_a !== 1'b1) begin failures++; $display("FAIL lw_read got=%b exp=1", mem_read_a); end
    tick();
    checks++; if (rsp_valid_a !== 2'b01) begin failures++; $display("FAIL lw_rsp_valid got=%b exp=01", rsp_valid_a); end
    checks++; if (rsp_rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rsp_rdata_a); end
    clr_req(0);
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_data;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, LB, SB, 32'h10, 32'h0);
    set_req(1, 1'b0, LB, SB, 32'h11, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_rdy  = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_data = (i % 2 == 1) ? 32'hFFFFFFBE : 32'hFFFFFFEF;
      #1;
      checks++; if (rdy_a !== exp_rdy) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, rdy_a, exp_rdy); end
      tick();
      checks++; if (rsp_valid_a !== exp_rdy) begin failures++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", i, rsp_valid_a, exp_rdy); end
      checks++; if (rsp_rdata_a !== exp_data) begin failures++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", i, rsp_rdata_a, exp_data); end
    end
    clr_req(0); clr_req(1);
  endtask

  task automatic test_priority();
    logic exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, LB, SB, 32'h10, 32'h0);
    set_req(1, 1'b0, LB, SB, 32'h11, 32'h0);
    for (int i = 0; i < 10; i++) begin
      exp_g = (i == 4 || i == 9);
      #1;
      checks++; if (gidx_b !== exp_g || rdy_b !== (exp_g ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL fp_grant[%0d] got=%b/%b exp=%b", i, gidx_b, rdy_b, exp_g);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (rdy_b !== 2'b01) begin failures++; $display("FAIL fp_pre_drop[%0d] got=%b exp=01", i, rdy_b); end
      tick();
    end
    clr_req(1);
    tick();
    set_req(1, 1'b0, LB, SB, 32'h11, 32'h0);
    for (int i = 0; i < 5; i++) begin
      exp_g = (i == 4);
      #1;
      checks++; if (gidx_b !== exp_g || rdy_b !== (exp_g ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL fp_after_drop[%0d] got=%b/%b exp=%b", i, gidx_b, rdy_b, exp_g);
      end
      tick();
    end
    clr_req(0); clr_req(1);
  endtask

  task automatic test_errors();
    set_req(1, 1'b0, LH, SB, 32'h21, 32'h0);
    #1;
    checks++; if (rdy_a !== 2'b10) begin failures++; $display("FAIL lh_ready got=%b exp=10", rdy_a); end
    checks++; if (mem_read_a !== 1'b0 || mem_write_a !== 1'b0) begin failures++; $display("FAIL lh_mem got=r%b w%b exp=r0 w0", mem_read_a, mem_write_a); end
    tick();
    checks++; if (rsp_valid_a !== 2'b10 || rsp_err_a !== 1'b1 || rsp_rdata_a !== 32'h0) begin
      failures++; $display("FAIL lh_rsp got=v%b e%b d%h exp=v10 e1 d0", rsp_valid_a, rsp_err_a, rsp_rdata_a);
    end
    set_req(1, 1'b1, LB, SW, 32'h3FE, 32'h12345678);
    #1;
    checks++; if (mem_write_a !== 1'b0) begin failures++; $display("FAIL sw_oor_write got=%b exp=0", mem_write_a); end
    tick();
    checks++; if (rsp_valid_a !== 2'b10 || rsp_err_a !== 1'b1) begin failures++; $display("FAIL sw_oor_rsp got=v%b e%b exp=v10 e1", rsp_valid_a, rsp_err_a); end
    clr_req(1);
    set_req(0, 1'b0, LW, SB, 32'h3FC, 32'h0);
    tick();
    checks++; if (rsp_err_a !== 1'b0 || rsp_rdata_a !== 32'h0) begin failures++; $display("FAIL top_word got=e%b d%h exp=e0 d0", rsp_err_a, rsp_rdata_a); end
    set_req(0, 1'b0, LB, SB, 32'h3FD, 32'h0);
    tick();
    checks++; if (rsp_err_a !== 1'b1) begin failures++; $display("FAIL range_lb got=%b exp=1", rsp_err_a); end
    set_req(0, 1'b0, 3'b101, SB, 32'h10, 32'h0);
    tick();
    checks++; if (rsp_err_a !== 1'b1 || rsp_rdata_a !== 32'h0) begin failures++; $display("FAIL bad_type got=e%b d%h exp=e1 d0", rsp_err_a, rsp_rdata_a); end
    set_req(0, 1'b0, LW, SB, 32'h12, 32'h0);
    tick();
    checks++; if (rsp_err_a !== 1'b1) begin failures++; $display("FAIL lw_misalign got=%b exp=1", rsp_err_a); end
    set_req(0, 1'b0, LHU, SB, 32'h12, 32'h0);
    tick();
    checks++; if (rsp_err_a !== 1'b0 || rsp_rdata_a !== 32'h0000DEAD) begin failures++; $display("FAIL lhu_ok got=e%b d%h exp=e0 d0000dead", rsp_err_a, rsp_rdata_a); end
    clr_req(0);
  endtask

  task automatic test_back_to_back_bytes();
    set_req(1, 1'b1, LB, SB, 32'h13, 32'h123456A5);
    #1;
    checks++; if (mem_write_a !== 1'b1 || gidx_a !== 1'b1) begin failures++; $display("FAIL sb_drive got=w%b g%b exp=w1 g1", mem_write_a, gidx_a); end
    tick();
    clr_req(1);
    set_req(0, 1'b0, LBU, SB, 32'h13, 32'h0);
    tick();
    checks++; if (rsp_valid_a !== 2'b01 || rsp_rdata_a !== 32'h000000A5) begin failures++; $display("FAIL lbu got=v%b d%h exp=v01 d000000a5", rsp_valid_a, rsp_rdata_a); end
    set_req(0, 1'b0, LB, SB, 32'h13, 32'h0);
    tick();
    checks++; if (rsp_rdata_a !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_sext got=%h exp=ffffffa5", rsp_rdata_a); end
    set_req(0, 1'b0, LW, SB, 32'h10, 32'h0);
    tick();
    checks++; if (rsp_rdata_a !== 32'hA5ADBEEF) begin failures++; $display("FAIL sb_one_byte got=%h exp=a5adbeef", rsp_rdata_a); end
    clr_req(0);
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b0, LW, SB, 32'h10, 32'h0);
    #1;
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, LW, SW, 32'h40, 32'h1);
    #1;
    checks++; if (rsp_valid_a !== 2'b01) begin failures++; $display("FAIL pending_rsp got=%b exp=01", rsp_valid_a); end
    checks++; if (rdy_a !== 2'b00 || mem_write_a !== 1'b0) begin failures++; $display("FAIL mid_rst_block got=r%b w%b exp=r00 w0", rdy_a, mem_write_a); end
    tick();
    rst = 1'b0;
    clr_req(0);
    #1;
    checks++; if (rsp_valid_a !== 2'b00 || rsp_rdata_a !== 32'h0) begin failures++; $display("FAIL mid_rst_clear got=v%b d%h exp=v00 d0", rsp_valid_a, rsp_rdata_a); end
    set_req(0, 1'b0, LB, SB, 32'h10, 32'h0);
    set_req(1, 1'b0, LB, SB, 32'h11, 32'h0);
    #1;
    checks++; if (gidx_a !== 1'b0 || rdy_a !== 2'b01) begin failures++; $display("FAIL rr_ptr_reset got=g%b r%b exp=g0 r01", gidx_a, rdy_a); end
    tick();
    clr_req(1);
    set_req(0, 1'b0, LW, SB, 32'h40, 32'h0);
    tick();
    checks++; if (rsp_valid_a !== 2'b01 || rsp_rdata_a !== 32'h0) begin failures++; $display("FAIL no_write_in_rst got=v%b d%h exp=v01 d0", rsp_valid_a, rsp_rdata_a); end
    clr_req(0);
  endtask

  initial begin
    rst       = 1'b1;
    mem_clr   = 1'b1;
    req_valid = 2'b00;
    test_reset();
    test_store_load();
    test_round_robin();
    test_priority();
    test_errors();
    test_back_to_back_bytes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported byte-addressable data memory path (store datapath, data memory, load datapath) between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is a DMA/debug loader.
- Grants at most one access per cycle and drives the memory-side control and address lines.
- Returns a registered response one cycle after the grant, with alignment checking and starvation-bounded priority.

Parameters:
- ARB_MODE, 0, 0 = round-robin between ports; 1 = fixed priority to port 0 with starvation guard for port 1.
- STARVE_LIMIT, 4, ARB_MODE=1 only: consecutive cycles port 1 may wait before it is forced a grant (1..15).
- MEM_BYTES, 1024, addressable bytes; an access with addr+3 >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port grant; one-hot or zero; combinational.
- req_we  in  2  per-port 1 = store, 0 = load.
- req_load_type  in  6  port i at [3i+2:3i]: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
- req_store_type  in  4  port i at [2i+1:2i]: 00 SB, 01 SH, 10 SW.
- req_addr  in  64  port i at [32i+31:32i]: byte address.
- req_wdata  in  64  port i at [32i+31:32i]: store data.
- mem_read  out  1  to data memory top.
- mem_write  out  1  to data memory top.
- mem_load_type  out  3  muxed load type.
- mem_store_type  out  2  muxed store type.
- mem_addr  out  32  muxed address.
- mem_wdata  out  32  muxed store data (rs2).
- mem_rdata  in  32  extended load result from load datapath (combinational).
- rsp_valid  out  2  per-port response valid, one-cycle pulse.
- rsp_rdata  out  32  load data for the port flagged in rsp_valid; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range access.
- grant_idx  out  1  port granted in the current cycle; valid when any req_ready is set.

Behaviour:
- Reset (rst=1 at clk edge): rsp_valid=0, rsp_rdata=0, rsp_err=0, rr_ptr=0, starve_cnt=0.
- While rst is high, req_ready=0, mem_read=0 and mem_write=0 combinationally.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - The requester must hold all request fields stable while valid is high and not granted.
  - Valid may not be withdrawn before the grant.
- Grant, ARB_MODE=0:
  - Only one valid port: that port is granted.
  - Both valid: grant port rr_ptr, then rr_ptr <= ~granted port.
  - rr_ptr updates only on a grant.
- Grant, ARB_MODE=1:
  - Port 0 wins ties unless starve_cnt == STARVE_LIMIT; then port 1 is granted.
  - starve_cnt increments (saturating) each cycle port 1 is valid and not granted.
  - starve_cnt clears on any port-1 grant or when req_valid[1]=0.
- Error check on the granted request:
  - err = (LH/LHU/SH and addr[0]) | (LW/SW and addr[1:0]!=0) | (addr > MEM_BYTES-4).
  - An illegal load_type on a read counts as an error.
- Memory drive:
  - Granted and not err: mem_read = ~we, mem_write = we; type, addr and wdata fields come from the granted port.
  - Otherwise mem_read = mem_write = 0; the type, addr and wdata fields hold port 0's values, which are don't-care.
  - The store commits at the grant clock edge inside the data memory.
- Response, latency 1:
  - At the edge ending the grant cycle: rsp_valid <= onehot(granted port), rsp_err <= err.
  - rsp_rdata <= (~we & ~err) ? mem_rdata : 0.
  - rsp_valid is 0 in cycles after no-grant cycles.
- Back-to-back: a new grant is allowed every cycle. A load granted the cycle after a store to the same address returns the newly stored data.
- Reset mid-operation: a grant in the same cycle as rst does not occur; no write is issued and no response is produced. Any pending response is cleared.
- Outputs never produce X when request inputs are X while req_valid=0.

Test Plan:
- Reset, then port 0 issues SW addr 0x10 wdata 0xDEADBEEF → req_ready=01, mem_write=1 that cycle. Next cycle rsp_valid=01, rsp_err=0. Port 0 then issues LW 0x10 → rsp_rdata=0xDEADBEEF.
- ARB_MODE=0, both ports hold LB requests for 4 cycles → grants alternate 0,1,0,1, and rsp_valid follows one cycle later as 01,10,01,10.
- ARB_MODE=1, STARVE_LIMIT=4, both continuously valid → port 0 granted 4 cycles, port 1 on the 5th, pattern repeats. Dropping req_valid[1] clears the counter.
- Port 1 issues LH addr 0x21 → no memory access (mem_read=0), next cycle rsp_valid=10, rsp_err=1, rsp_rdata=0. Port 1 issues SW addr 0x3FE → error, memory unchanged.
- Store SB 0xA5 at 0x13 via port 1, then LBU 0x13 and LB 0x13 via port 0 → rsp_rdata=0x000000A5 then 0xFFFFFFA5.
- Assert rst in the cycle port 0 presents SW 0x40=0x1 → no write (a later LW 0x40 returns 0), rsp_valid=0 the next cycle, rr_ptr=0.
